// File: rtl/fsub_pipe.sv
// fsub_pipe: 3-stage binary32 subtractor y = x1 - x2 (align / add-sub / normalize) with valid/ready.
// Define FSUB_ADD_SEL_EN to add the op port (op=1 computes x1 + x2).
module fsub_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        in_valid,
   output logic        in_ready,
`ifdef FSUB_ADD_SEL_EN
   input  logic        op,
`endif
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
);
   logic        w_ld1, w_ld2, w_ld3;
   logic        w_s2e, w_swap, w_pm, w_sgn;
   logic [7:0]  w_ea, w_eb, w_ebig, w_sm;
   logic [22:0] w_mb, w_ms;
   logic        r_v1, r_sgn1, r_pm1, r_nr1;
   logic [7:0]  r_eb1, r_sm1;
   logic [22:0] r_mb1, r_ms1;
   logic [24:0] w_shs, w_na, w_nb, w_near;
   logic [25:0] w_big, w_far;
   logic        r_v2, r_sgn2, r_nr2;
   logic [7:0]  r_eb2;
   logic [25:0] r_d2;
   logic [4:0]  w_lz;
   logic [24:0] w_nsh;
   logic [8:0]  w_ne;
   logic [7:0]  w_fe;
   logic [22:0] w_fm;
   logic [31:0] w_y;
   logic        r_v3;
   logic [31:0] r_y;

   assign w_ld3    = ~r_v3 | out_ready;
   assign w_ld2    = ~r_v2 | w_ld3;
   assign w_ld1    = ~r_v1 | w_ld2;
   assign in_ready = w_ld1;
   assign out_valid = r_v3;
   assign y        = r_y;

`ifdef FSUB_ADD_SEL_EN
   assign w_s2e = op ? x2[31] : ~x2[31];
`else
   assign w_s2e = ~x2[31];
`endif
   assign w_ea   = x1[30:23];
   assign w_eb   = x2[30:23];
   assign w_swap = w_eb > w_ea;
   assign w_ebig = w_swap ? w_eb : w_ea;
   assign w_sm   = w_swap ? w_eb - w_ea : w_ea - w_eb;
   assign w_mb   = w_swap ? x2[22:0] : x1[22:0];
   assign w_ms   = w_swap ? x1[22:0] : x2[22:0];
   assign w_pm   = x1[31] ^ w_s2e;
   assign w_sgn  = (x1[30:0] > x2[30:0]) ? x1[31] : w_s2e;

   // Near path (effective subtract, exponents within 1) keeps an exact 25b difference.
   assign w_shs  = {1'b1, r_ms1, 1'b0} >> r_sm1;
   assign w_big  = {2'b01, r_mb1, 1'b0};
   assign w_far  = r_pm1 ? w_big - {1'b0, w_shs} : w_big + {1'b0, w_shs};
   assign w_na   = {1'b1, r_mb1, 1'b0};
   assign w_nb   = {1'b1, r_ms1, 1'b0};
   assign w_near = r_sm1[0] ? w_na - {2'b01, r_ms1} : (w_na >= w_nb ? w_na - w_nb : w_nb - w_na);

   always_comb begin
      w_lz = 5'd0;
      for (int i = 0; i < 25; i++) if (r_d2[i]) w_lz = 5'(24 - i);
      w_nsh = r_d2[24:0] << w_lz;
      w_ne  = {1'b0, r_eb2} - {4'b0, w_lz};
      w_fe  = r_d2[25] ? r_eb2 + 8'd1 : r_d2[24] ? r_eb2 : (r_eb2 == 8'd0 ? 8'd0 : r_eb2 - 8'd1);
      w_fm  = r_d2[25] ? r_d2[24:2] : r_d2[24] ? r_d2[23:1] : r_d2[22:0];
      w_y   = !r_nr2 ? {r_sgn2, w_fe, w_fm} :
              ~|w_nsh ? 32'd0 : {r_sgn2, w_ne[8] ? 8'd0 : w_ne[7:0], w_nsh[23:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_y  <= 32'd0;
      end else begin
         if (w_ld1) r_v1 <= in_valid;
         if (w_ld1 && in_valid) begin
            r_sgn1 <= w_sgn;
            r_eb1  <= w_ebig;
            r_mb1  <= w_mb;
            r_ms1  <= w_ms;
            r_sm1  <= w_sm;
            r_pm1  <= w_pm;
            r_nr1  <= (w_sm <= 8'd1) & w_pm;
         end
         if (w_ld2) r_v2 <= r_v1;
         if (w_ld2 && r_v1) begin
            r_sgn2 <= r_sgn1;
            r_eb2  <= r_eb1;
            r_nr2  <= r_nr1;
            r_d2   <= r_nr1 ? {1'b0, w_near} : w_far;
         end
         if (w_ld3) r_v3 <= r_v2;
         if (w_ld3 && r_v2) r_y <= w_y;
      end
   end
endmodule

// File: tb/tb_fsub_pipe.sv
// tb_fsub_pipe: directed and randomized checks of fsub_pipe against an arithmetic reference model.
module tb_fsub_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] x1 = '0, x2 = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] y;
`ifdef FSUB_ADD_SEL_EN
   logic        op = 1'b0;
`endif
   int n_tests = 0, n_fail = 0;
   logic [31:0] q[$];

   fsub_pipe dut (
      .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(in_ready),
`ifdef FSUB_ADD_SEL_EN
      .op(op),
`endif
      .y(y), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic cur_op();
`ifdef FSUB_ADD_SEL_EN
      return op;
`else
      return 1'b0;
`endif
   endfunction

   // Reference: value-level arithmetic on 25b significands {1,m,0}.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic o);
      logic   s2e, sgn, sub;
      int     ea, eb, ebig, sm, lz, ex;
      longint ma, mb, mbig, msm, d, mant;
      s2e = o ? b[31] : ~b[31];
      sub = a[31] ^ s2e;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (longint'(1) << 24) | (longint'(a[22:0]) << 1);
      mb = (longint'(1) << 24) | (longint'(b[22:0]) << 1);
      if (eb > ea) begin ebig = eb; mbig = mb; msm = ma; sm = eb - ea; end
      else begin ebig = ea; mbig = ma; msm = mb; sm = ea - eb; end
      sgn = (a[30:0] > b[30:0]) ? a[31] : s2e;
      if (sm <= 1 && sub) begin
         d = mbig - (msm >> sm);
         if (d < 0) d = -d;
         if (d == 0) return 32'd0;
         lz = 0;
         while (d < (longint'(1) << 24)) begin d = d * 2; lz++; end
         mant = (d >> 1) & 'h7FFFFF;
         ex = ebig - lz;
         if (ex < 0) ex = 0;
      end else begin
         d = (sm >= 25) ? 0 : (msm >> sm);
         d = sub ? mbig - d : mbig + d;
         if (d >= (longint'(1) << 25)) begin ex = ebig + 1; mant = (d >> 2) & 'h7FFFFF; end
         else if (d >= (longint'(1) << 24)) begin ex = ebig; mant = (d >> 1) & 'h7FFFFF; end
         else begin ex = (ebig > 0) ? ebig - 1 : 0; mant = d & 'h7FFFFF; end
      end
      return {sgn, 8'(ex), 23'(mant)};
   endfunction

   task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
      int ea, eb, mode;
      logic [22:0] fa, fb;
      ea = $urandom_range(0, 254);
      mode = $urandom_range(0, 3);
      fa = 23'($urandom);
      fb = 23'($urandom);
      if (mode == 0) eb = ea;
      else if (mode == 1) eb = (ea == 0) ? 1 : (ea == 254) ? 253 : ($urandom_range(0, 1) != 0 ? ea + 1 : ea - 1);
      else if (mode == 2) eb = $urandom_range(0, 254);
      else begin
         eb = ea;
         fb = ($urandom_range(0, 1) != 0) ? fa : fa ^ 23'(1 << $urandom_range(0, 22));
      end
      a = {1'($urandom), 8'(ea), fa};
      b = {1'($urandom), 8'(eb), fb};
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || y !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: out_valid=%b y=%h, want out_valid=0 y=00000000", out_valid, y);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] va[6] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000, 32'h7F000000};
      logic [31:0] vb[6] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h00C00000, 32'hFF000000};
      logic [31:0] ve[6] = '{32'h40000000, 32'h00000000, 32'hBF000000, 32'h40000000, 32'h80000000, 32'h7F800000};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         x1 = va[i]; x2 = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: in_ready=%b want 1", i, in_ready); end
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== (c == 3)) begin
               n_fail++;
               $display("FAIL dir%0d_latency cycle %0d: out_valid=%b want %b", i, c, out_valid, c == 3);
            end
         end
         n_tests++;
         if (y !== ve[i]) begin n_fail++; $display("FAIL dir%0d_value: y=%h want %h", i, y, ve[i]); end
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drain: out_valid=%b want 0", i, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a[4], b[4], e[4];
      for (int i = 0; i < 4; i++) begin rnd_pair(a[i], b[i]); e[i] = model(a[i], b[i], cur_op()); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         x1 = a[i]; x2 = b[i]; in_valid = 1'b1; out_ready = 1'b0;
         #1;
         n_tests++;
         if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want %b", i, in_ready, i < 3); end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== e[0]) begin
         n_fail++;
         $display("FAIL bp_hold: in_ready=%b out_valid=%b y=%h want 0 1 %h", in_ready, out_valid, y, e[0]);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) out_ready = 1'b1; else in_valid = 1'b0;
         #1;
         n_tests++;
         if (out_valid !== 1'b1 || y !== e[k]) begin
            n_fail++;
            $display("FAIL bp_out%0d: out_valid=%b y=%h want 1 %h", k, out_valid, y, e[k]);
         end
         if (k == 0) begin
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fourth_accept: in_ready=%b want 1", in_ready); end
         end
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] a, b;
      int seen = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rnd_pair(a, b);
         a[30:23] = 8'd100; b[30:23] = 8'd90;
         x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || y === 32'd0) begin
         n_fail++;
         $display("FAIL mid_prefill: out_valid=%b y=%h want 1 and nonzero", out_valid, y);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || y !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset: out_valid=%b y=%h want 0 00000000", out_valid, y);
      end
      rst = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL mid_dropped: %0d stale outputs seen, want 0", seen); end
   endtask

`ifdef FSUB_ADD_SEL_EN
   task automatic test_op_add();
      @(negedge clk);
      x1 = 32'h3F800000; x2 = 32'h3F800000; op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; op = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || y !== 32'h40000000) begin
         n_fail++;
         $display("FAIL op_add: out_valid=%b y=%h want 1 40000000", out_valid, y);
      end
      @(negedge clk);
   endtask
`endif

   task automatic test_random(input int n);
      logic [31:0] a, b, e;
      logic take = 1'b0;
      int sent = 0, got = 0, cyc = 0;
      q.delete();
      while ((sent < n || q.size() > 0) && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (take) in_valid = 1'b0;
         if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
            rnd_pair(a, b);
            x1 = a; x2 = b; in_valid = 1'b1;
`ifdef FSUB_ADD_SEL_EN
            op = 1'($urandom_range(0, 1));
`endif
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_unexpected: y=%h with no outstanding op", y);
            end else begin
               e = q.pop_front();
               got++;
               if (y !== e) begin n_fail++; $display("FAIL rand_value%0d: y=%h want %h", got, y, e); end
            end
         end
         take = in_valid && in_ready;
         if (take) begin q.push_back(model(x1, x2, cur_op())); sent++; end
      end
      n_tests++;
      if (sent != n || q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_complete: sent=%0d outstanding=%0d want sent=%0d outstanding=0", sent, q.size(), n);
      end
      @(negedge clk);
      in_valid = 1'b0;
`ifdef FSUB_ADD_SEL_EN
      op = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
`ifdef FSUB_ADD_SEL_EN
      test_op_add();
`endif
      test_random(4000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
